// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as a fixed-latency
// multi-cycle op and services MTHI/MTLO with no latency.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W       = 32;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
    logic               wr_q, wr_d;
    logic               busy_d;
    logic [W-1:0]       hi_d, lo_d;

    logic [2*W-1:0]     mul_s, mul_u;
    logic               is_signed_div, a_neg, b_neg;
    logic [W-1:0]       div_n, div_d, d_safe, quo, rem;
    logic [W-1:0]       res_hi, res_lo;
    logic               res_wr;

    // Result datapath: division is done on magnitudes so the most-negative / -1
    // case wraps to 0x80000000 without relying on signed-division overflow.
    always_comb begin
        mul_s = $signed({{W{A[W-1]}}, A}) * $signed({{W{B[W-1]}}, B});
        mul_u = {{W{1'b0}}, A} * {{W{1'b0}}, B};

        is_signed_div = (op == OP_DIV);
        a_neg  = is_signed_div & A[W-1];
        b_neg  = is_signed_div & B[W-1];
        div_n  = a_neg ? (-A) : A;
        div_d  = b_neg ? (-B) : B;
        d_safe = (div_d == '0) ? W'(1) : div_d;
        quo    = div_n / d_safe;
        rem    = div_n % d_safe;
        if (a_neg ^ b_neg) quo = -quo;
        if (a_neg)         rem = -rem;

        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        case (op)
            OP_MULT:  {res_hi, res_lo} = mul_s;
            OP_MULTU: {res_hi, res_lo} = mul_u;
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
                res_wr = (B != '0);
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        wr_d      = wr_q;
        busy_d    = busy;
        hi_d      = HI;
        lo_d      = LO;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            temp_hi_d = res_hi;
                            temp_lo_d = res_lo;
                            wr_d      = res_wr;
                            cnt_d     = (op == OP_DIV || op == OP_DIVU) ? CNT_W'(DIV_CYCLES)
                                                                       : CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = temp_hi_q;
                        lo_d = temp_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
            wr_q      <= 1'b0;
            busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            wr_q      <= wr_d;
            busy      <= busy_d;
            HI        <= hi_d;
            LO        <= lo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results, busy length,
// ignored starts, zero divisor, async reset mid-op and back-to-back ops.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    int n;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch a multi-cycle op, scramble operands afterwards, and measure busy length.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input string tag);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 3'd7; A = ~a; B = ~b;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd7; A = '0; B = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        reset = 1'b1;
        tick();

        // Test 1: signed multiply
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 5, "mult");
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFE);

        // Test 2: unsigned multiply and signed divide
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 5, "multu");
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 10, "div");
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);
        run_op(3'd2, 32'h00000007, 32'hFFFFFFFE, 10, "div_negb");
        check("div_negb_lo", LO, 32'hFFFFFFFD);
        check("div_negb_hi", HI, 32'h00000001);
        run_op(3'd3, 32'h00000064, 32'h00000007, 10, "divu");
        check("divu_lo", LO, 32'h0000000E);
        check("divu_hi", HI, 32'h00000002);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
        check("div_ovf_lo", LO, 32'h80000000);
        check("div_ovf_hi", HI, 32'h00000000);

        // Test 3: MTHI/MTLO then divide by zero leaves HI/LO untouched
        start = 1'b1; op = 3'd4; A = 32'h0000AAAA;
        tick();
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", HI, 32'h0000AAAA);
        op = 3'd5; A = 32'h00005555;
        tick();
        start = 1'b0; op = 3'd7;
        check("mtlo_lo", LO, 32'h00005555);
        run_op(3'd3, 32'h00001234, 32'h00000000, 10, "divu_zero");
        check("divu_zero_hi", HI, 32'h0000AAAA);
        check("divu_zero_lo", LO, 32'h00005555);

        // op 6 has no effect
        start = 1'b1; op = 3'd6; A = 32'h12345678;
        tick();
        start = 1'b0; op = 3'd7;
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_hi", HI, 32'h0000AAAA);

        // Test 4: MTHI while busy is ignored, MTLO in IDLE is immediate
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        tick();
        start = 1'b0; op = 3'd7;
        tick();
        start = 1'b1; op = 3'd4; A = 32'h0000DEAD;
        tick();
        start = 1'b0; op = 3'd7;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        check("ign_busy_cycles", 32'(n), 32'd3);
        check("ign_hi", HI, 32'h00000000);
        check("ign_lo", LO, 32'h0000000F);
        start = 1'b1; op = 3'd5; A = 32'h0000BEEF;
        tick();
        start = 1'b0; op = 3'd7;
        check("mtlo2_lo", LO, 32'h0000BEEF);
        check("mtlo2_busy", 32'(busy), 32'd0);

        // Test 5: async reset mid-divide, cnt at 4
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd3;
        tick();
        start = 1'b0; op = 3'd7;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", HI, 32'h0);
        check("arst_lo", LO, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_hi", HI, 32'h0);
        check("post_rst_lo", LO, 32'h0);

        // Test 6: back-to-back multiply started the cycle busy falls
        run_op(3'd0, 32'd2, 32'd3, 5, "b2b_first");
        check("b2b_first_lo", LO, 32'h00000006);
        run_op(3'd1, 32'h00010000, 32'h00010000, 5, "b2b_second");
        check("b2b_second_hi", HI, 32'h00000001);
        check("b2b_second_lo", LO, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
